psum_acc_bank: RTL and testbench

//  Multi-pass partial-sum accumulation and activation bank placed after the MAC array/OFIFO path.

---
 rtl/psum_acc_bank.sv | 204 ++++++++++++++++++++
 tb/tb_psum_acc_bank.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_acc_bank.sv
`timescale 1ns/1ps
// psum_acc_bank
//   Multi-pass partial-sum accumulation and activation bank. It sits after
//   the MAC array / OFIFO path.
//   Operation:
//     - num_pass passes of num_vec vectors are accumulated into a local
//       buffer. Pass 0 overwrites the buffer; later passes do a per-channel
//       signed saturating add.
//     - The finished tile is then drained vector-by-vector, with optional
//       ReLU applied on the way out.
//   Ports:
//     clk, reset       clock; asynchronous active-high reset
//     start            begin a tile (honoured only in IDLE); latches num_vec,
//                      num_pass and relu_en
//     num_vec          vectors per pass (0 -> 1, >depth -> depth)
//     num_pass         passes to accumulate (0 -> 1)
//     relu_en          apply max(x,0) per channel on drain
//     in_valid/in_ready/in     input vector handshake, channel c at [psum_bw*c +: psum_bw]
//     out_valid/out_ready/out  output vector handshake; out is 0 when out_valid=0
//     busy             state != IDLE
//     done             one-cycle pulse after the final output handshake
module psum_acc_bank #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  parameter int pass_bw = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(depth+1)-1:0] num_vec,
  input  logic [pass_bw-1:0]         num_pass,
  input  logic                       relu_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [psum_bw*col-1:0]     in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [psum_bw*col-1:0]     out,
  output logic                       busy,
  output logic                       done
);

  localparam int VW = $clog2(depth + 1);
  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int W  = psum_bw * col;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      nv_last;
  logic [pass_bw-1:0] pass;
  logic [pass_bw-1:0] np_last;
  logic               relu_q;

  logic [PW-1:0]      nv_clamp;
  logic [pass_bw-1:0] np_clamp;

  logic [W-1:0]       mem [depth];
  logic [W-1:0]       rd;
  logic [W-1:0]       acc_sum;
  logic [W-1:0]       act;

  logic               in_fire;
  logic               out_fire;
  logic               vec_last;
  logic               pass_last;

  // Config is stored as "last index" so the end-of-pass and end-of-tile tests
  // are plain equality compares against the running counters.
  always_comb begin
    nv_clamp = '0;
    if (num_vec == '0)
      nv_clamp = '0;
    else if (num_vec > VW'(depth))
      nv_clamp = PW'(depth - 1);
    else
      nv_clamp = PW'(num_vec - 1'b1);
  end

  assign np_clamp = (num_pass == '0) ? '0 : num_pass - 1'b1;

  assign vec_last  = (ptr == nv_last);
  assign pass_last = (pass == np_last);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start)
          state_nxt = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_fire && vec_last && pass_last)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_fire && vec_last)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      pass    <= '0;
      nv_last <= '0;
      np_last <= '0;
      relu_q  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            nv_last <= nv_clamp;
            np_last <= np_clamp;
            relu_q  <= relu_en;
            ptr     <= '0;
            pass    <= '0;
          end
        end
        ACCUM: begin
          if (in_fire) begin
            if (vec_last) begin
              ptr  <= '0;
              pass <= pass + 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (vec_last) begin
              ptr  <= '0;
              done <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: ptr <= '0;
      endcase
    end
  end

  // The buffer is not reset. The read is combinational, so a beat written
  // this cycle is seen by the next beat even when it hits the same entry
  // (num_vec=1).
  always_ff @(posedge clk) begin
    if (in_fire)
      mem[ptr] <= (pass == '0) ? in : acc_sum;
  end

  assign rd = mem[ptr];

  logic signed [psum_bw:0]   s;
  logic        [psum_bw-1:0] a;
  logic        [psum_bw-1:0] b;
  logic        [psum_bw-1:0] x;

  always_comb begin
    acc_sum = '0;
    act     = '0;
    s       = '0;
    a       = '0;
    b       = '0;
    x       = '0;
    for (int unsigned c = 0; c < col; c++) begin
      a = rd[c*psum_bw +: psum_bw];
      b = in[c*psum_bw +: psum_bw];
      s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
      // Overflow shows up as the two top bits of the widened sum differing.
      if (s[psum_bw] != s[psum_bw-1])
        acc_sum[c*psum_bw +: psum_bw] = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                                   : {1'b0, {(psum_bw-1){1'b1}}};
      else
        acc_sum[c*psum_bw +: psum_bw] = s[psum_bw-1:0];
      x = rd[c*psum_bw +: psum_bw];
      act[c*psum_bw +: psum_bw] = (relu_q && x[psum_bw-1]) ? '0 : x;
    end
  end

  assign out = out_valid ? act : '0;

endmodule

// File: tb/tb_psum_acc_bank.sv
`timescale 1ns/1ps
module tb_psum_acc_bank;

  localparam int COL  = 8;
  localparam int PB   = 16;
  localparam int DEPTH = 16;
  localparam int PBW  = 8;
  localparam int W    = COL * PB;
  localparam int VW   = $clog2(DEPTH + 1);
  localparam int MAXV = 2**(PB-1) - 1;
  localparam int MINV = -(2**(PB-1));

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [VW-1:0]  num_vec;
  logic [PBW-1:0] num_pass;
  logic           relu_en;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           busy;
  logic           done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] stim [8][16];
  logic [W-1:0] expv [16];

  typedef struct {
    bit           relu;
    int           np;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  psum_acc_bank #(.col(COL), .psum_bw(PB), .depth(DEPTH), .pass_bw(PBW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_vec   (num_vec),
    .num_pass  (num_pass),
    .relu_en   (relu_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int eff_nv(input int nv);
    return (nv == 0) ? 1 : ((nv > DEPTH) ? DEPTH : nv);
  endfunction

  function automatic int eff_np(input int np);
    return (np == 0) ? 1 : np;
  endfunction

  // Reference: sum the passes channel by channel in integers, clamping after
  // each add, then apply ReLU.
  function automatic logic [W-1:0] model(input int v, input int np, input bit relu);
    logic [W-1:0]         r;
    logic signed [PB-1:0] t;
    int                   acc;
    r = '0;
    for (int c = 0; c < COL; c++) begin
      t   = stim[0][v][c*PB +: PB];
      acc = t;
      for (int p = 1; p < np; p++) begin
        t   = stim[p][v][c*PB +: PB];
        acc = acc + t;
        if (acc > MAXV) acc = MAXV;
        if (acc < MINV) acc = MINV;
      end
      if (relu && acc < 0) acc = 0;
      r[c*PB +: PB] = PB'(acc);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] r;
    for (int c = 0; c < COL; c++) begin
      case ($urandom_range(0, 5))
        0:       r[c*PB +: PB] = 16'h7FFF;
        1:       r[c*PB +: PB] = 16'h8000;
        default: r[c*PB +: PB] = PB'($urandom);
      endcase
    end
    return r;
  endfunction

  // Config inputs are scrambled right after start to show they are latched.
  task automatic start_tile(input int nv, input int np, input bit relu);
    @(negedge clk);
    start    = 1'b1;
    num_vec  = VW'(nv);
    num_pass = PBW'(np);
    relu_en  = relu;
    @(negedge clk);
    start    = 1'b0;
    relu_en  = ~relu;
    num_vec  = VW'($urandom);
    num_pass = PBW'($urandom);
    check("busy_after_start", busy, 1);
  endtask

  task automatic feed(input int nv, input int np, input int gap_max);
    int w;
    for (int p = 0; p < np; p++) begin
      for (int v = 0; v < nv; v++) begin
        in_valid = 1'b0;
        in_data  = {4{$urandom}};
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = stim[p][v];
        w = 0;
        while (!in_ready && w < 20) begin
          @(negedge clk);
          w++;
        end
        check("in_ready_wait", in_ready, 1);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic drain(input int nv, input int stall_v, input int stall_len, input bit rand_stall);
    logic [W-1:0] hold;
    int w;
    int stall;
    out_ready = 1'b0;
    check("out_valid_latency", out_valid, 1);
    for (int v = 0; v < nv; v++) begin
      w = 0;
      while (!out_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      check("out_valid_wait", out_valid, 1);
      check("in_ready_drain", in_ready, 0);
      stall = (v == stall_v) ? stall_len : (rand_stall ? $urandom_range(0, 2) : 0);
      if (stall > 0) begin
        hold = out_data;
        repeat (stall) begin
          @(negedge clk);
          check("stall_hold", out_data, hold);
          check("stall_valid", out_valid, 1);
        end
      end
      out_ready = 1'b1;
      check($sformatf("out_v%0d", v), out_data, expv[v]);
      @(negedge clk);
      out_ready = 1'b0;
    end
    check("done_pulse", done, 1);
    check("busy_idle", busy, 0);
    check("out_zero_idle", out_data, 0);
    @(negedge clk);
    check("done_once", done, 0);
  endtask

  task automatic model_tile(input int nv, input int np, input bit relu,
                            input int gap_max, input int stall_v, input int stall_len,
                            input bit rand_stall);
    int env, enp;
    env = eff_nv(nv);
    enp = eff_np(np);
    for (int p = 0; p < enp; p++)
      for (int v = 0; v < env; v++)
        stim[p][v] = rand_vec();
    for (int v = 0; v < env; v++)
      expv[v] = model(v, enp, relu);
    start_tile(nv, np, relu);
    feed(env, enp, gap_max);
    drain(env, stall_v, stall_len, rand_stall);
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 2, {8{16'h7000}}, {8{16'h2000}}, {8{16'h7FFF}}};
    tbl[1] = '{1'b0, 2, {8{16'h9000}}, {8{16'hE000}}, {8{16'h8000}}};
    tbl[2] = '{1'b0, 2, {8{16'h7FFF}}, {8{16'h8000}}, {8{16'hFFFF}}};
    tbl[3] = '{1'b0, 2,
               {16'h7000, 16'h9000, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h8000, 16'h4000, 16'hC000},
               {16'h2000, 16'hE000, 16'h8000, 16'h0001, 16'h0001, 16'hFFFF, 16'h4000, 16'hC000},
               {16'h7FFF, 16'h8000, 16'hFFFF, 16'h0002, 16'h0000, 16'h8000, 16'h7FFF, 16'h8000}};
    tbl[4] = '{1'b1, 1,
               {16'h7FFF, 16'hFFFF, 16'h0001, 16'h8001, 16'h8000, 16'h0007, 16'h0000, 16'hFFFD},
               '0,
               {16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0007, 16'h0000, 16'h0000}};
    tbl[5] = '{1'b0, 1,
               {16'h7FFF, 16'hFFFF, 16'h0001, 16'h8001, 16'h8000, 16'h0007, 16'h0000, 16'hFFFD},
               '0,
               {16'h7FFF, 16'hFFFF, 16'h0001, 16'h8001, 16'h8000, 16'h0007, 16'h0000, 16'hFFFD}};
    tbl[6] = '{1'b1, 2, {4{16'h7000, 16'h9000}}, {4{16'h2000, 16'hE000}}, {4{16'h7FFF, 16'h0000}}};

    reset     = 1'b1;
    start     = 1'b0;
    num_vec   = '0;
    num_pass  = '0;
    relu_en   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;

    // Two vectors, single pass, pass-through.
    stim[0][0] = {8{16'h0005}};
    stim[0][1] = {8{16'hFFFE}};
    expv[0]    = {8{16'h0005}};
    expv[1]    = {8{16'hFFFE}};
    start_tile(2, 1, 1'b0);
    feed(2, 1, 0);
    drain(2, -1, 0, 1'b0);

    // Three passes of v+p; a start pulse while busy must be ignored.
    for (int p = 0; p < 3; p++)
      for (int v = 0; v < 4; v++)
        stim[p][v] = {8{16'(v + p)}};
    for (int v = 0; v < 4; v++)
      expv[v] = {8{16'(3 * v + 3)}};
    start_tile(4, 3, 1'b0);
    start    = 1'b1;
    num_vec  = VW'(1);
    num_pass = PBW'(1);
    @(negedge clk);
    start = 1'b0;
    check("busy_ignore_start", busy, 1);
    feed(4, 3, 0);
    drain(4, -1, 0, 1'b0);

    // Single-entry saturation / ReLU vectors (num_vec=1 exercises back-to-back RMW).
    for (int i = 0; i < 7; i++) begin
      stim[0][0] = tbl[i].a;
      stim[1][0] = tbl[i].b;
      expv[0]    = tbl[i].exp;
      start_tile(1, tbl[i].np, tbl[i].relu);
      feed(1, tbl[i].np, 1);
      drain(1, -1, 0, 1'b0);
    end

    // Gapped input, 5-cycle output stall on vector 1.
    model_tile(5, 2, 1'b0, 3, 1, 5, 1'b1);

    // Randomized tiles, including out-of-range and zero configs.
    for (int t = 0; t < 20; t++)
      model_tile($urandom_range(0, 18), $urandom_range(0, 4), 1'($urandom), 2, -1, 0, 1'b1);

    // Reset during pass 1 of 3.
    for (int v = 0; v < 4; v++) stim[0][v] = rand_vec();
    start_tile(4, 3, 1'b0);
    feed(4, 1, 0);
    feed(2, 1, 0);
    in_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out", out_data, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end

    // num_vec=0, num_pass=0 behaves as 1x1.
    model_tile(0, 0, 1'b0, 0, -1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
